mdu: RTL and testbench
======================

# mdu

Multiply/divide unit for the E stage of the five-stage pipeline; the producer of the busy signal the stall logic consumes. Accepts a start-qualified op with two 32-bit operands, holds Busy for a fixed operation latency, and commits results to architectural HI/LO on completion. Register moves to HI/LO complete in one cycle. HI/LO are read by the datapath through a mux outside this block.

## Interface
- MULT_CYCLES, 5, Busy duration in cycles for mult-class ops (≥1)
- DIV_CYCLES, 10, Busy duration in cycles for div-class ops (≥1)
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high
- A  input  32  operand rs (dividend / multiplicand / mthi-mtlo source)
- B  input  32  operand rt (divisor / multiplier)
- MDUOp  input  4  op code (mdu_pkg encoding)
- Start  input  1  qualifies MDUOp this cycle; also the pipeline's DE_MDUEN-side indication
- Busy  output  1  operation in flight
- HI  output  32  architectural HI
- LO  output  32  architectural LO

## Operation
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10; others treated as NONE.
- FSM: IDLE, RUN. IDLE + Start + mult/div-class op → latch A, B, op; load counter with MULT_CYCLES or DIV_CYCLES; → RUN. RUN: counter decrements each edge; at the edge where it reaches 0 write HI/LO, → IDLE.
- MTHI/MTLO with Start in IDLE: HI←A or LO←A at that edge; no RUN, Busy stays 0.
- Start while RUN: ignored entirely (stall logic guarantees it never happens; bench checks the ignore).
- MULT: {HI,LO} = signed A × signed B (64-bit). MULTU: unsigned.
- DIV: LO = A/B truncated toward zero, HI = remainder with sign of A. 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU unsigned.
- Divide by zero (B=0): HI/LO unchanged; Busy still runs DIV_CYCLES.
- Result computed from latched operands only; A/B changes during RUN do not affect it.

## Timing
- Reset: Busy=0, HI=0, LO=0, FSM=IDLE, counter=0, immediately on reset assertion, independent of clk.
- Reset mid-RUN: operation aborted, HI/LO=0, no commit.
- Start sampled at edge k: Busy=1 from after edge k through edge k+N (N=MULT_CYCLES or DIV_CYCLES); HI/LO new values and Busy=0 visible after edge k+N. Busy high exactly N cycles.
- Back-to-back: new Start accepted at edge k+N (same edge as commit) is not accepted; earliest accepted Start is at edge k+N+1 when Busy=0 is observed.
- MTHI/MTLO: visible after the sampling edge; zero latency otherwise.
- Busy is registered; no combinational path from inputs to any output.

## Configuration
- MDU_MADD_EN defined: MADD/MADDU → {HI,LO} += product (signed/unsigned), MSUB/MSUBU → {HI,LO} −= product, 64-bit wrap, MULT_CYCLES latency, accumulate base is HI/LO value at the commit edge.
- Undefined: op codes 7–10 treated as NONE (no Busy, no state change).

## Structure
- mdu_pkg: op code localparams, default MULT_CYCLES/DIV_CYCLES, op-class helpers (is_mult, is_div, is_move).
- Sub-module mdu_arith: purely combinational 64-bit result from latched op, operands, current HI/LO; top holds FSM, counter, HI/LO registers.

## Test plan
- Reset mid-RUN after MULT 3×4: assert reset at cycle 2 → Busy=0, HI=LO=0 immediately, no commit afterwards.
- MULT A=0xFFFFFFFF, B=2 → Busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=-7, B=2 → Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- MTHI A=0x12345678 then DIVU B=0 → HI=0x12345678 after one edge, Busy 10 cycles, HI/LO unchanged at end.
- MULT 3×4 started, Start DIV 9/3 at cycle 2 of RUN → ignored; LO=12 at commit, Busy drops after exactly 5 cycles.
- With MDU_MADD_EN: HI=0, LO=10, MADD 3×4 → LO=22; MSUBU 5×5 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; without macro MADD → Busy stays 0, LO unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared op encoding, default latencies, FSM state type and op-class helpers for the MDU.
// Optional multiply-accumulate ops are enabled with the MDU_MADD_EN macro.
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    // Accumulate ops share the multiplier latency, so they count as mult-class.
    function automatic logic is_mult(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
               (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`else
        return (op == OP_MULT) || (op == OP_MULTU);
`endif
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_move(input logic [3:0] op);
        return (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational result path: 64-bit {HI,LO} from latched op/operands and current HI/LO.
// Accumulate ops are only decoded when MDU_MADD_EN is defined.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        wr_o
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [63:0]        acc;
    logic [63:0]        res;
    logic [31:0]        divisor_u;
    logic [31:0]        abs_a;
    logic [31:0]        abs_b;
    logic [31:0]        mag_q;
    logic [31:0]        mag_r;
    logic [31:0]        sq;
    logic [31:0]        sr;
    logic               b_zero;

    assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign prod_u = {32'b0, a_i} * {32'b0, b_i};
    assign acc    = {hi_i, lo_i};

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign b_zero    = (b_i == 32'd0);
    assign divisor_u = b_zero ? 32'd1 : b_i;
    assign abs_a     = a_i[31] ? (32'd0 - a_i) : a_i;
    assign abs_b     = b_zero ? 32'd1 : (b_i[31] ? (32'd0 - b_i) : b_i);
    assign mag_q     = abs_a / abs_b;
    assign mag_r     = abs_a % abs_b;
    assign sq        = (a_i[31] ^ b_i[31]) ? (32'd0 - mag_q) : mag_q;
    assign sr        = a_i[31] ? (32'd0 - mag_r) : mag_r;

    always_comb begin
        res  = acc;
        wr_o = 1'b1;
        case (op_i)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV: begin
                if (b_zero) wr_o = 1'b0;
                else        res  = {sr, sq};
            end
            OP_DIVU: begin
                if (b_zero) wr_o = 1'b0;
                else        res  = {a_i % divisor_u, a_i / divisor_u};
            end
`ifdef MDU_MADD_EN
            OP_MADD:  res = acc + prod_s;
            OP_MADDU: res = acc + prod_u;
            OP_MSUB:  res = acc - prod_s;
            OP_MSUBU: res = acc - prod_u;
`endif
            default:  wr_o = 1'b0;
        endcase
    end

    assign hi_o = res[63:32];
    assign lo_o = res[31:0];

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: two-state FSM with a latency counter, HI/LO architectural registers.
// MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU; otherwise those codes behave as NONE.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             res_wr;

    mdu_arith u_arith (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .hi_i (hi_q),
        .lo_i (lo_q),
        .hi_o (res_hi),
        .lo_o (res_lo),
        .wr_o (res_wr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Start is only honoured in IDLE; the commit edge itself still belongs to RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (is_mult(MDUOp) || is_div(MDUOp)) begin
                        state_d = ST_RUN;
                        cnt_d   = is_mult(MDUOp) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        op_d    = MDUOp;
                        a_d     = A;
                        b_d     = B;
                    end else if (MDUOp == OP_MTHI) begin
                        hi_d = A;
                    end else if (MDUOp == OP_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (res_wr) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign Busy = (state_q == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed op scenarios plus random MULTU/DIVU through a scoreboard queue.
module tb_mdu;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .MDUOp (MDUOp),
        .Start (Start),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Start = 1'b1;
        MDUOp = op;
        A     = a;
        B     = b;
        @(negedge clk);
        Start = 1'b0;
        MDUOp = OP_NONE;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic do_move(input logic [3:0] op, input logic [31:0] a);
        drive_start(op, a, 32'd0);
    endtask

    // Push the expected {HI,LO}, start the op, count Busy cycles, then pop and compare.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc, input logic [63:0] exp_res);
        int cnt;
        logic [63:0] exp;
        exp_q.push_back(exp_res);
        drive_start(op, a, b);
        cnt = 0;
        while (Busy && cnt < 100) begin
            cnt++;
            A = $urandom;
            B = $urandom;
            @(negedge clk);
        end
        total++;
        if (cnt !== exp_cyc) begin
            bad++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, cnt, exp_cyc);
        end
        exp = exp_q.pop_front();
        total++;
        if ({HI, LO} !== exp) begin
            bad++;
            $display("FAIL %s result: got HI=%h LO=%h expected HI=%h LO=%h",
                     name, HI, LO, exp[63:32], exp[31:0]);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #3;
        total++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: got Busy=%b HI=%h LO=%h expected 0/0/0", Busy, HI, LO);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        do_move(OP_MTLO, 32'h0000_0055);
        do_move(OP_MTHI, 32'h0000_0066);
        drive_start(OP_MULT, 32'd3, 32'd4);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid_run: got Busy=%b HI=%h LO=%h expected 0/0/0", Busy, HI, LO);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        total++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            bad++;
            $display("FAIL reset_no_commit: got Busy=%b HI=%h LO=%h expected 0/0/0", Busy, HI, LO);
        end
    endtask

    task automatic test_mult;
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFF, 32'd2, MC, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, MC, 64'h0000_0001_FFFF_FFFE);
    endtask

    task automatic test_div;
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, DC, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DC, 64'h0000_0000_8000_0000);
    endtask

    task automatic test_move_divzero;
        do_move(OP_MTHI, 32'h1234_5678);
        total++;
        if (HI !== 32'h1234_5678 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL mthi: got HI=%h Busy=%b expected 12345678/0", HI, Busy);
        end
        do_move(OP_MTLO, 32'hCAFE_F00D);
        total++;
        if (LO !== 32'hCAFE_F00D || Busy !== 1'b0) begin
            bad++;
            $display("FAIL mtlo: got LO=%h Busy=%b expected cafef00d/0", LO, Busy);
        end
        run_op("divu_zero", OP_DIVU, 32'd77, 32'd0, DC, 64'h1234_5678_CAFE_F00D);
        run_op("div_zero", OP_DIV, 32'hFFFF_FF00, 32'd0, DC, 64'h1234_5678_CAFE_F00D);
    endtask

    // Start during RUN, including on the commit edge, must be dropped.
    task automatic test_ignore;
        int cnt;
        drive_start(OP_MULT, 32'd3, 32'd4);
        cnt = 0;
        while (Busy && cnt < 100) begin
            cnt++;
            if (cnt == 2) begin
                Start = 1'b1; MDUOp = OP_DIV; A = 32'd9; B = 32'd3;
            end else if (cnt == MC) begin
                Start = 1'b1; MDUOp = OP_MTLO; A = 32'h0000_0BAD; B = 32'd0;
            end else begin
                Start = 1'b0; MDUOp = OP_NONE;
            end
            @(negedge clk);
        end
        Start = 1'b0;
        MDUOp = OP_NONE;
        total++;
        if (cnt !== MC) begin
            bad++;
            $display("FAIL ignore_busy_cycles: got %0d expected %0d", cnt, MC);
        end
        total++;
        if (HI !== 32'd0 || LO !== 32'd12) begin
            bad++;
            $display("FAIL ignore_result: got HI=%h LO=%h expected 0/0000000c", HI, LO);
        end
        repeat (3) @(negedge clk);
        total++;
        if (Busy !== 1'b0 || LO !== 32'd12) begin
            bad++;
            $display("FAIL ignore_no_restart: got Busy=%b LO=%h expected 0/0000000c", Busy, LO);
        end
    endtask

    task automatic test_madd;
        do_move(OP_MTHI, 32'd0);
        do_move(OP_MTLO, 32'd10);
`ifdef MDU_MADD_EN
        run_op("madd", OP_MADD, 32'd3, 32'd4, MC, 64'd22);
        run_op("msubu", OP_MSUBU, 32'd5, 32'd5, MC, 64'hFFFF_FFFF_FFFF_FFFD);
`else
        drive_start(OP_MADD, 32'd3, 32'd4);
        total++;
        if (Busy !== 1'b0 || LO !== 32'd10 || HI !== 32'd0) begin
            bad++;
            $display("FAIL madd_disabled: got Busy=%b HI=%h LO=%h expected 0/0/0000000a", Busy, HI, LO);
        end
        repeat (MC + 1) @(negedge clk);
        total++;
        if (Busy !== 1'b0 || LO !== 32'd10) begin
            bad++;
            $display("FAIL madd_disabled_late: got Busy=%b LO=%h expected 0/0000000a", Busy, LO);
        end
`endif
    endtask

    // Random unsigned ops issued back to back; expected values from plain integer arithmetic.
    task automatic test_back_to_back;
        logic [31:0] a, b;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = 32'($urandom_range(1, 1000));
            if (i % 2 == 0)
                run_op("rand_multu", OP_MULTU, a, b, MC, {32'd0, a} * {32'd0, b});
            else
                run_op("rand_divu", OP_DIVU, a, b, DC, {a % b, a / b});
        end
    endtask

    initial begin
        Start = 1'b0;
        MDUOp = OP_NONE;
        A     = 32'd0;
        B     = 32'd0;
        reset = 1'b0;
        test_reset;
        test_reset_mid_run;
        test_mult;
        test_div;
        test_move_divzero;
        test_ignore;
        test_madd;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
